// File: rtl/overcurrent_guard.sv
// rtl/overcurrent_guard.sv - BCD current decode, hysteresis trip, cooldown/retry and lockout guard
module overcurrent_guard #(
  parameter int SAMPLE_PERIOD       = 10000000,
  parameter int TRIP_LEVEL          = 95,
  parameter int CLEAR_LEVEL         = 85,
  parameter int TRIP_SAMPLES        = 3,
  parameter int COOLDOWN_SAMPLES    = 20,
  parameter int MAX_RETRIES         = 3,
  parameter int RETRY_RESET_SAMPLES = 100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] current_value,
  input  logic        run_req,
  input  logic        clear_fault,
  output logic        motor_en,
  output logic        fault,
  output logic        lockout,
  output logic [7:0]  current_pct,
  output logic [7:0]  peak_pct,
  output logic [3:0]  trip_count,
  output logic        bcd_error
);

  localparam int CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CW-1:0] SP_LAST   = CW'(SAMPLE_PERIOD - 1);
  localparam logic [7:0]    TRIP_PCT  = 8'(TRIP_LEVEL);
  localparam logic [7:0]    CLEAR_PCT = 8'(CLEAR_LEVEL);
  localparam logic [15:0]   TRIP_N    = 16'(TRIP_SAMPLES);
  localparam logic [15:0]   COOL_N    = 16'(COOLDOWN_SAMPLES);
  localparam logic [15:0]   RRS_N     = 16'(RETRY_RESET_SAMPLES);
  localparam logic [3:0]    MAXR_N    = 4'(MAX_RETRIES);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_TRIP    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  // sample timing
  logic [CW-1:0] cnt_q;
  logic          tick;

  // decode stage
  logic [3:0] units, tenths, hund;
  logic [7:0] pct_new;
  logic       invalid;
  logic [7:0] pct_q, peak_q;
  logic       inv_q, samp_q, bcd_err_q;

  // evaluation stage
  state_t      state_q, state_d;
  logic [15:0] over_q, over_d;
  logic [15:0] clean_q, clean_d;
  logic [15:0] cool_q, cool_d;
  logic [15:0] cool_inc;
  logic [3:0]  trip_q, trip_d;
  logic        motor_en_q, motor_en_d;
  logic        fault_q, fault_d;
  logic        lockout_q, lockout_d;
  logic        over_smp, clean_smp;

  assign tick = (cnt_q == SP_LAST);

  // Free-running sample counter; tick marks the last cycle of each period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Digit layout: [3:0] hundreds-of-percent, [7:4] tens, [11:8] ones.
  // The raw sum wraps to 8 bits for invalid samples, which are fail-safe anyway.
  always_comb begin
    units   = current_value[3:0];
    tenths  = current_value[7:4];
    hund    = current_value[11:8];
    pct_new = 8'(units) * 8'd100 + 8'(tenths) * 8'd10 + 8'(hund);
    invalid = (units > 4'd1) || (tenths > 4'd9) || (hund > 4'd9);
  end

  // Capture the decoded sample on tick and maintain peak / sticky BCD error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pct_q     <= '0;
      peak_q    <= '0;
      inv_q     <= 1'b0;
      samp_q    <= 1'b0;
      bcd_err_q <= 1'b0;
    end else begin
      samp_q <= tick;
      if (tick) begin
        pct_q <= pct_new;
        inv_q <= invalid;
      end
      if (clear_fault) begin
        peak_q    <= '0;
        bcd_err_q <= 1'b0;
      end else if (tick) begin
        if (pct_new > peak_q) begin
          peak_q <= pct_new;
        end
        if (invalid) begin
          bcd_err_q <= 1'b1;
        end
      end
    end
  end

  // Classify the decoded sample; invalid BCD never counts as clean.
  always_comb begin
    over_smp  = inv_q || (pct_q >= TRIP_PCT);
    clean_smp = !inv_q && (pct_q < CLEAR_PCT);
  end

  // Next-state and counter logic; clear_fault overrides the sample evaluation.
  always_comb begin
    state_d  = state_q;
    over_d   = over_q;
    clean_d  = clean_q;
    cool_d   = cool_q;
    trip_d   = trip_q;
    cool_inc = (cool_q >= COOL_N) ? COOL_N : (cool_q + 16'd1);

    if (clear_fault) begin
      state_d = ST_RUN;
      over_d  = '0;
      clean_d = '0;
      cool_d  = '0;
      trip_d  = '0;
    end else if (samp_q) begin
      case (state_q)
        ST_RUN: begin
          if (over_smp) begin
            over_d = over_q + 16'd1;
          end else if (clean_smp) begin
            over_d = '0;
          end
          if (clean_smp) begin
            if ((clean_q + 16'd1) >= RRS_N) begin
              clean_d = '0;
              trip_d  = '0;
            end else begin
              clean_d = clean_q + 16'd1;
            end
          end else begin
            clean_d = '0;
          end
          if (over_smp && ((over_q + 16'd1) >= TRIP_N)) begin
            state_d = ST_TRIP;
            trip_d  = (trip_q == 4'hF) ? trip_q : (trip_q + 4'd1);
            over_d  = '0;
            cool_d  = '0;
          end
        end
        ST_TRIP: begin
          cool_d = cool_inc;
          if ((cool_inc >= COOL_N) && clean_smp) begin
            state_d = (trip_q >= MAXR_N) ? ST_LOCKOUT : ST_RUN;
            clean_d = '0;
            over_d  = '0;
          end
        end
        ST_LOCKOUT: begin
          state_d = ST_LOCKOUT;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end

    motor_en_d = run_req && (state_d == ST_RUN);
    fault_d    = (state_d != ST_RUN);
    lockout_d  = (state_d == ST_LOCKOUT);
  end

  // State, counters and registered outputs; motor_en tracks the next state so
  // a trip drops it two cycles after the tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      over_q     <= '0;
      clean_q    <= '0;
      cool_q     <= '0;
      trip_q     <= '0;
      motor_en_q <= 1'b0;
      fault_q    <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      over_q     <= over_d;
      clean_q    <= clean_d;
      cool_q     <= cool_d;
      trip_q     <= trip_d;
      motor_en_q <= motor_en_d;
      fault_q    <= fault_d;
      lockout_q  <= lockout_d;
    end
  end

  assign motor_en    = motor_en_q;
  assign fault       = fault_q;
  assign lockout     = lockout_q;
  assign current_pct = pct_q;
  assign peak_pct    = peak_q;
  assign trip_count  = trip_q;
  assign bcd_error   = bcd_err_q;

endmodule

// File: tb/tb_overcurrent_guard.sv
// tb/tb_overcurrent_guard.sv - self-checking bench for overcurrent_guard
module tb_overcurrent_guard;

  localparam int SP = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] current_value;
  logic        run_req;
  logic        clear_fault;
  logic        motor_en, fault, lockout, bcd_error;
  logic [7:0]  current_pct, peak_pct;
  logic [3:0]  trip_count;

  overcurrent_guard #(
    .SAMPLE_PERIOD(SP), .TRIP_LEVEL(95), .CLEAR_LEVEL(85), .TRIP_SAMPLES(3),
    .COOLDOWN_SAMPLES(4), .MAX_RETRIES(2), .RETRY_RESET_SAMPLES(6)
  ) dut (
    .clk(clk), .reset_n(reset_n), .current_value(current_value), .run_req(run_req),
    .clear_fault(clear_fault), .motor_en(motor_en), .fault(fault), .lockout(lockout),
    .current_pct(current_pct), .peak_pct(peak_pct), .trip_count(trip_count),
    .bcd_error(bcd_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] cv;
    logic        run;
    logic        me, f, lk;
    logic [7:0]  pct, peak;
    logic [3:0]  tc;
    logic        bcd;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   tb_cnt;
  logic prev_me, prev_f;

  // Bench-side copy of the sample period so ticks are known without probing the DUT.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_cnt <= 0;
    else          tb_cnt <= (tb_cnt == SP - 1) ? 0 : tb_cnt + 1;
  end

  function automatic vec_t v(logic [11:0] cv, logic run, logic me, logic f, logic lk,
                             int pct, int peak, int tc, logic bcd);
    vec_t r;
    r.cv = cv; r.run = run; r.me = me; r.f = f; r.lk = lk;
    r.pct = 8'(pct); r.peak = 8'(peak); r.tc = 4'(tc); r.bcd = bcd;
    return r;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t t);
    vec_t e;
    int guard;
    current_value = t.cv;
    run_req       = t.run;
    exp_q.push_back(t);
    @(negedge clk);
    guard = 0;
    while (tb_cnt != SP - 1 && guard < 4 * SP) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 4 * SP) check($sformatf("tick_timeout[%0d]", idx), 0, 1);
    @(posedge clk); #1;
    check($sformatf("pct_t1[%0d]", idx), current_pct, t.pct);
    check($sformatf("me_t1[%0d]", idx), motor_en, prev_me);
    check($sformatf("fault_t1[%0d]", idx), fault, prev_f);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check($sformatf("motor_en[%0d]", idx), motor_en, e.me);
    check($sformatf("fault[%0d]", idx), fault, e.f);
    check($sformatf("lockout[%0d]", idx), lockout, e.lk);
    check($sformatf("current_pct[%0d]", idx), current_pct, e.pct);
    check($sformatf("peak_pct[%0d]", idx), peak_pct, e.peak);
    check($sformatf("trip_count[%0d]", idx), trip_count, e.tc);
    check($sformatf("bcd_error[%0d]", idx), bcd_error, e.bcd);
    prev_me = e.me;
    prev_f  = e.f;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_motor_en"}, motor_en, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_lockout"}, lockout, 0);
    check({tag, "_pct"}, current_pct, 0);
    check({tag, "_peak"}, peak_pct, 0);
    check({tag, "_trip_count"}, trip_count, 0);
    check({tag, "_bcd_error"}, bcd_error, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Segment A: decode, hysteresis, cooldown/retry, escalation to lockout.
    tbl.push_back(v(12'h590, 1, 1, 0, 0,  95,  95, 0, 0));
    tbl.push_back(v(12'h050, 1, 1, 0, 0,  50,  95, 0, 0));
    tbl.push_back(v(12'h001, 1, 1, 0, 0, 100, 100, 0, 0));
    tbl.push_back(v(12'h080, 1, 1, 0, 0,  80, 100, 0, 0));
    tbl.push_back(v(12'h790, 1, 1, 0, 0,  97, 100, 0, 0));
    tbl.push_back(v(12'h790, 1, 1, 0, 0,  97, 100, 0, 0));
    tbl.push_back(v(12'h090, 1, 1, 0, 0,  90, 100, 0, 0));
    tbl.push_back(v(12'h790, 1, 0, 1, 0,  97, 100, 1, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(12'h050, 1, 0, 1, 0, 50, 100, 1, 0));
    tbl.push_back(v(12'h050, 1, 1, 0, 0,  50, 100, 1, 0));
    tbl.push_back(v(12'h790, 1, 1, 0, 0,  97, 100, 1, 0));
    tbl.push_back(v(12'h790, 1, 1, 0, 0,  97, 100, 1, 0));
    tbl.push_back(v(12'h080, 1, 1, 0, 0,  80, 100, 1, 0));
    tbl.push_back(v(12'h790, 1, 1, 0, 0,  97, 100, 1, 0));
    tbl.push_back(v(12'h790, 1, 1, 0, 0,  97, 100, 1, 0));
    tbl.push_back(v(12'h790, 1, 0, 1, 0,  97, 100, 2, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(v(12'h090, 1, 0, 1, 0, 90, 100, 2, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(v(12'h050, 1, 0, 1, 1, 50, 100, 2, 0));
    // Segment B (after clear): trip, recover, clean-run decay of trip_count.
    tbl.push_back(v(12'h790, 1, 1, 0, 0,  97,  97, 0, 0));
    tbl.push_back(v(12'h790, 1, 1, 0, 0,  97,  97, 0, 0));
    tbl.push_back(v(12'h790, 1, 0, 1, 0,  97,  97, 1, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(12'h050, 1, 0, 1, 0, 50, 97, 1, 0));
    for (int i = 0; i < 6; i++) tbl.push_back(v(12'h050, 1, 1, 0, 0, 50, 97, 1, 0));
    tbl.push_back(v(12'h050, 1, 1, 0, 0,  50,  97, 0, 0));
    // Segment C (run_req low): invalid BCD is fail-safe over-current.
    tbl.push_back(v(12'h00A, 0, 0, 0, 0, 232, 232, 0, 1));
    tbl.push_back(v(12'h00A, 0, 0, 0, 0, 232, 232, 0, 1));
    tbl.push_back(v(12'h00A, 0, 0, 1, 0, 232, 232, 1, 1));

    reset_n       = 1'b0;
    run_req       = 1'b0;
    clear_fault   = 1'b0;
    current_value = 12'h000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");

    reset_n = 1'b1;
    run_req = 1'b1;
    prev_me = 1'b1;
    prev_f  = 1'b0;

    for (int i = 0; i < 31; i++) run_vec(i, tbl[i]);

    // Single-cycle clear_fault releases the lockout and wipes history.
    @(negedge clk); clear_fault = 1'b1;
    @(negedge clk); clear_fault = 1'b0;
    check("clr_fault", fault, 0);
    check("clr_lockout", lockout, 0);
    check("clr_trip_count", trip_count, 0);
    check("clr_peak", peak_pct, 0);
    check("clr_motor_en", motor_en, 1);
    check("clr_pct_kept", current_pct, 50);
    prev_me = 1'b1;
    prev_f  = 1'b0;

    for (int i = 31; i < 44; i++) run_vec(i, tbl[i]);

    // run_req falling drops motor_en one cycle later.
    @(negedge clk); run_req = 1'b0;
    @(negedge clk);
    check("runreq_drop_motor_en", motor_en, 0);
    check("runreq_drop_fault", fault, 0);
    prev_me = 1'b0;

    for (int i = 44; i < 47; i++) run_vec(i, tbl[i]);

    // Asynchronous reset mid-TRIP, between clock edges.
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk); reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
